// File: rtl/player_damage_controller_pkg.sv
// rtl/player_damage_controller_pkg.sv - shared game-engine constants for player damage handling
//
// Purpose: FSM state encoding, default hit-point/timing constants and the
//          saturating hit-point arithmetic used by player_damage_controller.
// Ports:   none (package).
package player_damage_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIVE  = 2'd1,
    ST_INVULN = 2'd2,
    ST_DEAD   = 2'd3
  } state_t;

  localparam int DEF_MAX_HP    = 20;
  localparam int DEF_INVULN_CS = 100;
  localparam int DEF_BLINK_CS  = 10;

  // Subtract damage, clamping at zero instead of wrapping.
  function automatic logic [7:0] hp_after_hit(input logic [7:0] hp, input logic [7:0] dmg);
    return (dmg >= hp) ? 8'd0 : (hp - dmg);
  endfunction

  // Add heal with a 9-bit sum so a large heal cannot wrap before the cap.
  function automatic logic [7:0] hp_after_heal(input logic [7:0] hp, input logic [7:0] amt,
                                               input logic [7:0] max_hp);
    logic [8:0] sum;
    sum = {1'b0, hp} + {1'b0, amt};
    return (sum > {1'b0, max_hp}) ? max_hp : sum[7:0];
  endfunction

endpackage

// File: rtl/invuln_timer.sv
// rtl/invuln_timer.sv - invulnerability countdown and blink generator
//
// Purpose: counts INVULN_CS centi-ticks after load, toggling blink every
//          BLINK_CS ticks from load and forcing blink low at expiry.
// Ports:   clk, clk_reset (async active-low), load (start window, blink=1),
//          centi_tick (10 ms pulse), done (tick that expires the window),
//          blink (registered display hide flag).
module invuln_timer
  import player_damage_controller_pkg::*;
#(
  parameter int INVULN_CS = DEF_INVULN_CS,
  parameter int BLINK_CS  = DEF_BLINK_CS
) (
  input  logic clk,
  input  logic clk_reset,
  input  logic load,
  input  logic centi_tick,
  output logic done,
  output logic blink
);

  localparam logic [7:0] INVULN_V   = 8'(INVULN_CS);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_CS - 1);

  logic [7:0] remain;
  logic [7:0] phase;

  // Combinational so the controller leaves INVULN on the same edge the count reaches zero.
  assign done = centi_tick && !load && (remain == 8'd1);

  always_ff @(posedge clk or negedge clk_reset) begin
    if (!clk_reset) begin
      remain <= 8'd0;
      phase  <= 8'd0;
      blink  <= 1'b0;
    end else if (load) begin
      remain <= INVULN_V;
      phase  <= 8'd0;
      blink  <= 1'b1;
    end else if (centi_tick && (remain != 8'd0)) begin
      remain <= remain - 8'd1;
      if (remain == 8'd1) begin
        phase <= 8'd0;
        blink <= 1'b0;
      end else if (phase == BLINK_LAST) begin
        phase <= 8'd0;
        blink <= ~blink;
      end else begin
        phase <= phase + 8'd1;
      end
    end
  end

endmodule

// File: rtl/player_damage_controller.sv
// rtl/player_damage_controller.sv - player hit-point FSM with invulnerability window
//
// Purpose: tracks player hit points, accepts damage from trigger overlaps,
//          applies heals, runs an invulnerability window after each hit.
// Ports:   clk, clk_reset (async active-low), centi_tick, game_start,
//          is_trigger_player/trigger_damage (damage source), heal_valid/heal_amount,
//          player_hp, is_invulnerable, player_dead, hit_pulse, player_blink (all registered).
module player_damage_controller
  import player_damage_controller_pkg::*;
#(
  parameter int MAX_HP    = DEF_MAX_HP,
  parameter int INVULN_CS = DEF_INVULN_CS,
  parameter int BLINK_CS  = DEF_BLINK_CS
) (
  input  logic       clk,
  input  logic       clk_reset,
  input  logic       centi_tick,
  input  logic       game_start,
  input  logic       is_trigger_player,
  input  logic [7:0] trigger_damage,
  input  logic       heal_valid,
  input  logic [7:0] heal_amount,
  output logic [7:0] player_hp,
  output logic       is_invulnerable,
  output logic       player_dead,
  output logic       hit_pulse,
  output logic       player_blink
);

  localparam logic [7:0] MAX_HP_V = 8'(MAX_HP);

  state_t     state;
  logic       hit_ok;
  logic [7:0] hit_hp;
  logic [7:0] heal_hp;
  logic       timer_load;
  logic       timer_done;

  always_comb begin
    hit_ok     = (state == ST_ALIVE) && is_trigger_player && (trigger_damage != 8'd0);
    hit_hp     = hp_after_hit(player_hp, trigger_damage);
    heal_hp    = hp_after_heal(player_hp, heal_amount, MAX_HP_V);
    // A fatal hit goes straight to DEAD, so the window only starts on survivable hits.
    timer_load = hit_ok && (hit_hp != 8'd0);
  end

  invuln_timer #(
    .INVULN_CS(INVULN_CS),
    .BLINK_CS (BLINK_CS)
  ) u_invuln_timer (
    .clk       (clk),
    .clk_reset (clk_reset),
    .load      (timer_load),
    .centi_tick(centi_tick),
    .done      (timer_done),
    .blink     (player_blink)
  );

  always_ff @(posedge clk or negedge clk_reset) begin
    if (!clk_reset) begin
      state           <= ST_IDLE;
      player_hp       <= MAX_HP_V;
      is_invulnerable <= 1'b0;
      player_dead     <= 1'b0;
      hit_pulse       <= 1'b0;
    end else begin
      hit_pulse <= hit_ok;
      case (state)
        ST_IDLE, ST_DEAD: begin
          if (game_start) begin
            state       <= ST_ALIVE;
            player_hp   <= MAX_HP_V;
            player_dead <= 1'b0;
          end
        end
        ST_ALIVE: begin
          // Hit has priority; a same-cycle heal is dropped.
          if (hit_ok) begin
            player_hp <= hit_hp;
            if (hit_hp == 8'd0) begin
              state       <= ST_DEAD;
              player_dead <= 1'b1;
            end else begin
              state           <= ST_INVULN;
              is_invulnerable <= 1'b1;
            end
          end else if (heal_valid) begin
            player_hp <= heal_hp;
          end
        end
        ST_INVULN: begin
          if (heal_valid) begin
            player_hp <= heal_hp;
          end
          if (timer_done) begin
            state           <= ST_ALIVE;
            is_invulnerable <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_damage_controller.sv
// tb/tb_player_damage_controller.sv - directed-vector bench for player_damage_controller
module tb_player_damage_controller;

  logic       clk = 1'b0;
  logic       clk_reset = 1'b0;
  logic       centi_tick = 1'b0;
  logic       game_start = 1'b0;
  logic       is_trigger_player = 1'b0;
  logic [7:0] trigger_damage = 8'd0;
  logic       heal_valid = 1'b0;
  logic [7:0] heal_amount = 8'd0;
  logic [7:0] player_hp;
  logic       is_invulnerable;
  logic       player_dead;
  logic       hit_pulse;
  logic       player_blink;

  int vectors = 0;
  int miscompares = 0;

  player_damage_controller dut (
    .clk              (clk),
    .clk_reset        (clk_reset),
    .centi_tick       (centi_tick),
    .game_start       (game_start),
    .is_trigger_player(is_trigger_player),
    .trigger_damage   (trigger_damage),
    .heal_valid       (heal_valid),
    .heal_amount      (heal_amount),
    .player_hp        (player_hp),
    .is_invulnerable  (is_invulnerable),
    .player_dead      (player_dead),
    .hit_pulse        (hit_pulse),
    .player_blink     (player_blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    centi_tick = 1'b1;
    repeat (n) step();
    centi_tick = 1'b0;
  endtask

  task automatic start_round();
    game_start = 1'b1;
    step();
    game_start = 1'b0;
  endtask

  task automatic hit_once(input logic [7:0] dmg);
    is_trigger_player = 1'b1;
    trigger_damage    = dmg;
    step();
    is_trigger_player = 1'b0;
    trigger_damage    = 8'd0;
  endtask

  initial begin
    // Reset state
    step();
    check("rst_hp", player_hp, 20);
    check("rst_inv", is_invulnerable, 0);
    check("rst_dead", player_dead, 0);
    check("rst_pulse", hit_pulse, 0);
    check("rst_blink", player_blink, 0);
    clk_reset = 1'b1;
    step();

    // IDLE ignores trigger
    hit_once(8'd5);
    check("idle_no_hit_hp", player_hp, 20);
    check("idle_no_pulse", hit_pulse, 0);

    // First hit
    start_round();
    check("start_hp", player_hp, 20);
    hit_once(8'd5);
    check("hit1_hp", player_hp, 15);
    check("hit1_pulse", hit_pulse, 1);
    check("hit1_inv", is_invulnerable, 1);
    check("hit1_blink", player_blink, 1);
    step();
    check("hit1_pulse_drop", hit_pulse, 0);

    // Blink cadence, trigger ignored while invulnerable
    is_trigger_player = 1'b1;
    trigger_damage    = 8'd5;
    ticks(9);
    check("blink_t9", player_blink, 1);
    ticks(1);
    check("blink_t10", player_blink, 0);
    ticks(9);
    check("blink_t19", player_blink, 0);
    ticks(1);
    check("blink_t20", player_blink, 1);
    ticks(10);
    check("blink_t30", player_blink, 0);
    check("inv_trig_hp", player_hp, 15);
    check("inv_trig_pulse", hit_pulse, 0);

    // Asynchronous reset mid-INVULN
    #2;
    clk_reset = 1'b0;
    #1;
    check("arst_hp", player_hp, 20);
    check("arst_inv", is_invulnerable, 0);
    check("arst_blink", player_blink, 0);
    check("arst_dead", player_dead, 0);
    step();
    clk_reset = 1'b1;
    step();
    step();
    check("post_rst_idle_hp", player_hp, 20);
    check("post_rst_idle_inv", is_invulnerable, 0);

    // Held trigger: hits every 100 ticks down to death
    start_round();
    step();
    check("hold_hit15", player_hp, 15);
    check("hold_pulse15", hit_pulse, 1);
    for (int k = 0; k < 3; k++) begin
      ticks(99);
      check("hold_still_inv", is_invulnerable, 1);
      ticks(1);
      check("hold_inv_end", is_invulnerable, 0);
      check("hold_blink_end", player_blink, 0);
      step();
      check("hold_hp", player_hp, 32'(10 - 5 * k));
      check("hold_pulse", hit_pulse, 1);
    end
    check("hold_dead", player_dead, 1);
    check("hold_dead_inv", is_invulnerable, 0);
    is_trigger_player = 1'b0;
    trigger_damage    = 8'd0;

    // DEAD ignores heal and game_start restarts
    heal_valid  = 1'b1;
    heal_amount = 8'd5;
    step();
    heal_valid = 1'b0;
    check("dead_heal_hp", player_hp, 0);
    start_round();
    check("restart_hp", player_hp, 20);
    check("restart_dead", player_dead, 0);

    // hp=3, dmg=10 -> straight to DEAD
    hit_once(8'd17);
    check("to3_hp", player_hp, 3);
    ticks(100);
    check("to3_alive", is_invulnerable, 0);
    hit_once(8'd10);
    check("over_hp", player_hp, 0);
    check("over_dead", player_dead, 1);
    check("over_inv", is_invulnerable, 0);
    check("over_blink", player_blink, 0);
    start_round();
    check("over_restart_hp", player_hp, 20);

    // Heal cap during INVULN, zero damage, heal+hit priority
    hit_once(8'd2);
    check("h18_hp", player_hp, 18);
    heal_valid  = 1'b1;
    heal_amount = 8'd5;
    step();
    heal_valid = 1'b0;
    check("heal_cap_hp", player_hp, 20);
    ticks(100);
    is_trigger_player = 1'b1;
    trigger_damage    = 8'd0;
    step();
    check("zero_dmg_hp", player_hp, 20);
    check("zero_dmg_pulse", hit_pulse, 0);
    check("zero_dmg_inv", is_invulnerable, 0);
    trigger_damage = 8'd4;
    heal_valid     = 1'b1;
    heal_amount    = 8'd5;
    step();
    is_trigger_player = 1'b0;
    heal_valid        = 1'b0;
    check("hit_wins_hp", player_hp, 16);
    check("hit_wins_pulse", hit_pulse, 1);

    // game_start in INVULN ignored, large heal cannot wrap
    start_round();
    check("inv_start_hp", player_hp, 16);
    check("inv_start_inv", is_invulnerable, 1);
    heal_valid  = 1'b1;
    heal_amount = 8'd255;
    step();
    heal_valid = 1'b0;
    check("heal255_hp", player_hp, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=%0d expected=%0d", vectors, 0);
    $fatal(1);
  end

endmodule

// File: doc/player_damage_controller.md
PLAYER_DAMAGE_CONTROLLER -- requirements
Module: player_damage_controller

Interface
REQ-001 Parameter MAX_HP, default 20: full/restart hit points (1..255).
REQ-002 Parameter INVULN_CS, default 100: invulnerability length after a hit, in centi-second ticks (1..255).
REQ-003 Parameter BLINK_CS, default 10: blink half-period in centi-second ticks (1..INVULN_CS).
REQ-004 clk  in  1  system clock; every register SHALL use its rising edge.
REQ-005 clk_reset  in  1  asynchronous, active-low reset.
REQ-006 centi_tick  in  1  one-clk pulse per 10 ms, synchronous to clk.
REQ-007 game_start  in  1  one-clk pulse requesting a new round.
REQ-008 is_trigger_player  in  1  level; player overlaps a damaging trigger object (from the trigger runtime stage).
REQ-009 trigger_damage  in  8  damage of the overlapping object; valid while is_trigger_player=1.
REQ-010 heal_valid  in  1  one-clk heal request.
REQ-011 heal_amount  in  8  HP added on heal_valid.
REQ-012 player_hp  out  8  current hit points.
REQ-013 is_invulnerable  out  1  high in state INVULN.
REQ-014 player_dead  out  1  high in state DEAD.
REQ-015 hit_pulse  out  1  one-clk pulse per accepted hit.
REQ-016 player_blink  out  1  display hide flag, toggled during INVULN.

Function
REQ-017 FSM states SHALL be IDLE, ALIVE, INVULN, DEAD; all outputs registered.
REQ-018 IDLE or DEAD + game_start: SHALL go to ALIVE, player_hp=MAX_HP, invuln counter=0, player_blink=0.
REQ-019 game_start in ALIVE or INVULN SHALL be ignored.
REQ-020 ALIVE + is_trigger_player=1 + trigger_damage!=0 SHALL accept a hit: player_hp <= max(player_hp-trigger_damage, 0), saturating, no wrap.
REQ-021 Accepted hit leaving player_hp>0: next state INVULN, counter=INVULN_CS, player_blink=1; leaving 0: next state DEAD.
REQ-022 hit_pulse SHALL be 1 in the clk cycle after the hit was accepted and 0 otherwise.
REQ-023 trigger_damage=0 SHALL NOT count as a hit (no state change, no pulse).
REQ-024 Trigger is level-sensitive: a trigger still asserted when INVULN ends SHALL be accepted as a hit in the first ALIVE cycle.
REQ-025 INVULN: is_is_trigger_player SHALL be ignored; each centi_tick decrements the counter; the tick taking it 1->0 SHALL return to ALIVE with player_blink=0.
REQ-026 INVULN: player_blink SHALL toggle every BLINK_CS centi_ticks, counted from INVULN entry.
REQ-027 heal_valid in ALIVE or INVULN: player_hp <= min(player_hp+heal_amount, MAX_HP) using 9-bit intermediate.
REQ-028 Same-cycle accepted hit and heal_valid in ALIVE: hit SHALL win, heal dropped.
REQ-029 heal_valid in IDLE or DEAD SHALL be ignored.
REQ-030 DEAD SHALL hold player_hp=0, ignore trigger and heal until game_start.

Reset
REQ-031 clk_reset=0 SHALL immediately force IDLE, player_hp=MAX_HP, counters=0, is_invulnerable=0, player_dead=0, hit_pulse=0, player_blink=0.
REQ-032 Reset asserted mid-INVULN or mid-hit SHALL discard pending pulse and timer; after release block waits for game_start.

Structure
REQ-033 State encoding and default MAX_HP/INVULN_CS/BLINK_CS SHALL live in the shared game-engine constants package.
REQ-034 Invulnerability/blink timing SHALL be a sub-module invuln_timer (load, centi_tick in; done, blink out).

Verification
REQ-035 Reset, game_start, trigger dmg=5 one clk -> player_hp 20->15, hit_pulse next clk, is_invulnerable=1.
REQ-036 Trigger held continuously dmg=5 -> hits exactly every 100 centi_ticks; hp 15,10,5,0 then player_dead=1.
REQ-037 hp=3, dmg=10 -> player_hp=0, DEAD, no INVULN; game_start -> hp=20, ALIVE.
REQ-038 hp=18, heal 5 -> 20; same cycle heal 5 + hit 4 in ALIVE -> 16.
REQ-039 INVULN with BLINK_CS=10 -> player_blink toggles after ticks 10,20,...; trigger during INVULN -> no hp change.
REQ-040 Reset asserted 30 ticks into INVULN -> IDLE, hp=20, all flags 0 immediately.
